// File: rtl/alu_accumulator_if.sv
// alu_accumulator_if: sequencer-to-ALU execute bus (operands in, accumulator/flags/done out)
interface alu_accumulator_if #(
   parameter int DATA_WIDTH = 8,
   parameter int INST_WIDTH = 8
);
   logic                  Exec;
   logic [INST_WIDTH-1:0] IR;
   logic [DATA_WIDTH-1:0] IBR;
   logic [DATA_WIDTH-1:0] MBR;
   logic [DATA_WIDTH-1:0] AR;
   logic [3:0]            Flags;
   logic                  Done;
   modport master (output Exec, IR, IBR, MBR, input AR, Flags, Done);
   modport slave  (input Exec, IR, IBR, MBR, output AR, Flags, Done);
endinterface

// File: rtl/alu_accumulator.sv
// alu_accumulator: accumulator/flags execute stage; optional shifter enabled by macro ALU_SHIFT_EN
`ifndef ZERO
`define ZERO 0
`endif
`ifndef CARRY
`define CARRY 1
`endif
`ifndef NEG
`define NEG 2
`endif
`ifndef OV
`define OV 3
`endif
`ifndef LOAD_X
`define LOAD_X 8'b0000_0001
`endif
`ifndef LOAD_I
`define LOAD_I 8'b0000_0101
`endif
module alu_accumulator #(
   parameter int DATA_WIDTH = 8,
   parameter int INST_WIDTH = 8
) (
   input logic             clk,
   input logic             arst,
   alu_accumulator_if.slave bus
);
   localparam int MSB = DATA_WIDTH - 1;
   logic [7:0]            ir;
   logic [DATA_WIDTH-1:0] ar_q, ar_d, op, lres, sres, res;
   logic [DATA_WIDTH:0]   wide, cin_w;
   logic [3:0]            flags_q, flags_d;
   logic                  done_q, done_d;
   logic                  sel_ok, is_arith, is_logic, is_ldx, is_ldi, is_shift, v, sc;
   assign ir = bus.IR[7:0];
   // decode plus arithmetic/logic datapath; subtract borrow falls out as the extra top bit
   always_comb begin
      sel_ok   = ir[5:3] == 3'b000;
      op       = ir[2] ? bus.IBR : bus.MBR;
      is_arith = ir[7:6] == 2'b01 && sel_ok;
      is_logic = ir[7:6] == 2'b10 && sel_ok;
      is_ldx   = ir == `LOAD_X;
      is_ldi   = ir == `LOAD_I;
      cin_w    = {{DATA_WIDTH{1'b0}}, ir[1] & flags_q[`CARRY]};
      wide     = ir[0] ? {1'b0, ar_q} - {1'b0, op} - cin_w : {1'b0, ar_q} + {1'b0, op} + cin_w;
      v        = (ar_q[MSB] == (op[MSB] ^ ir[0])) && (wide[MSB] != ar_q[MSB]);
      lres     = ir[1] ? (ir[0] ? ~(ar_q ^ op) : ar_q ^ op) : (ir[0] ? ~(ar_q & op) : ~(ar_q | op));
   end
`ifdef ALU_SHIFT_EN
   // shift/rotate: rotates pass through the carry flag, plain shifts zero-fill
   always_comb begin
      is_shift = ir[7:2] == 6'b001100;
      sc       = ir[0] ? ar_q[0] : ar_q[MSB];
      sres     = ir[0] ? {ir[1] & flags_q[`CARRY], ar_q[MSB:1]} : {ar_q[MSB-1:0], ir[1] & flags_q[`CARRY]};
   end
`else
   assign is_shift = 1'b0;
   assign sc       = 1'b0;
   assign sres     = '0;
`endif
   // next state: only an Exec strobe changes AR/flags; unrecognised opcodes still pulse Done
   always_comb begin
      res     = is_arith ? wide[MSB:0] : is_logic ? lres : is_ldx ? bus.MBR : is_ldi ? bus.IBR : is_shift ? sres : ar_q;
      ar_d    = ar_q;
      flags_d = flags_q;
      done_d  = bus.Exec;
      if (bus.Exec && (is_arith || is_logic || is_ldx || is_ldi || is_shift)) begin
         ar_d           = res;
         flags_d[`ZERO] = res == '0;
         flags_d[`NEG]  = res[MSB];
      end
      if (bus.Exec && (is_arith || is_shift)) flags_d[`CARRY] = is_arith ? wide[DATA_WIDTH] : sc;
      if (bus.Exec && (is_arith || is_logic || is_shift)) flags_d[`OV] = is_arith & v;
   end
   // state registers, cleared asynchronously
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         ar_q    <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
      end else begin
         ar_q    <= ar_d;
         flags_q <= flags_d;
         done_q  <= done_d;
      end
   end
   assign bus.AR    = ar_q;
   assign bus.Flags = flags_q;
   assign bus.Done  = done_q;
endmodule
